// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// One outstanding request at a time; handshake is imem_req & imem_gnt.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requester feeding the IF/ID
// register, with a one-entry skid buffer for decode stalls and redirect flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_stage_if.master imem,
  input  logic         stall_D,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic [31:0]  instr_D,
  output logic [31:0]  PC_D,
  output logic         valid_D
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_f_r, pc_f_s, pc_inc_s;
  logic        kill_r, kill_s;
  logic [31:0] buf_instr_r, buf_pc_r;
  logic        buf_load_s;
  logic [31:0] instr_d_r, pc_d_r;
  logic        valid_d_r;
  logic        ifid_load_s;
  logic [31:0] ifid_instr_s, ifid_pc_s;
  logic        ifid_valid_s;
  logic        imem_req_s;
  logic        accept_s;

  // Request is only driven from REQ and never while reset is held.
  always_comb begin
    imem_req_s = (state_r == S_REQ) & ~reset;
    accept_s   = imem_req_s & imem.imem_gnt;
    pc_inc_s   = pc_f_r + 32'd4;
  end

  assign imem.imem_req  = imem_req_s;
  assign imem.imem_addr = pc_f_r;
  assign instr_D        = instr_d_r;
  assign PC_D           = pc_d_r;
  assign valid_D        = valid_d_r;

  // Next-state, next-PC and IF/ID update selection.
  always_comb begin
    state_s      = state_r;
    pc_f_s       = pc_f_r;
    kill_s       = kill_r;
    buf_load_s   = 1'b0;
    ifid_load_s  = 1'b0;
    ifid_instr_s = 32'h0000_0000;
    ifid_pc_s    = 32'h0000_0000;
    ifid_valid_s = 1'b0;
    if (redirect) begin
      // Flush wins over stall: IF/ID takes a bubble, target is word aligned.
      pc_f_s      = redirect_pc & 32'hFFFF_FFFC;
      ifid_load_s = 1'b1;
      kill_s      = 1'b0;
      case (state_r)
        S_REQ: begin
          if (accept_s) begin
            state_s = S_WAIT;
            kill_s  = 1'b1;
          end else begin
            state_s = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            state_s = S_REQ;
          end else begin
            state_s = S_WAIT;
            kill_s  = 1'b1;
          end
        end
        S_FULL:  state_s = S_REQ;
        default: state_s = S_REQ;
      endcase
    end else begin
      ifid_load_s = ~stall_D;
      case (state_r)
        S_REQ: begin
          if (accept_s) begin
            state_s = S_WAIT;
          end else begin
            state_s = S_REQ;
          end
        end
        S_WAIT: begin
          if (!imem.imem_rvalid) begin
            state_s = S_WAIT;
          end else if (kill_r) begin
            kill_s  = 1'b0;
            state_s = S_REQ;
          end else if (!stall_D) begin
            ifid_instr_s = imem.imem_rdata;
            ifid_pc_s    = pc_f_r;
            ifid_valid_s = 1'b1;
            pc_f_s       = pc_inc_s;
            state_s      = S_REQ;
          end else begin
            buf_load_s = 1'b1;
            state_s    = S_FULL;
          end
        end
        S_FULL: begin
          if (!stall_D) begin
            ifid_instr_s = buf_instr_r;
            ifid_pc_s    = buf_pc_r;
            ifid_valid_s = 1'b1;
            pc_f_s       = pc_inc_s;
            state_s      = S_REQ;
          end else begin
            state_s = S_FULL;
          end
        end
        default: begin
          state_s = S_REQ;
          kill_s  = 1'b0;
        end
      endcase
    end
  end

  // State, PC, skid buffer and IF/ID registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_REQ;
      pc_f_r      <= RESET_PC;
      kill_r      <= 1'b0;
      buf_instr_r <= 32'h0000_0000;
      buf_pc_r    <= 32'h0000_0000;
      instr_d_r   <= 32'h0000_0000;
      pc_d_r      <= 32'h0000_0000;
      valid_d_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_f_r  <= pc_f_s;
      kill_r  <= kill_s;
      if (buf_load_s) begin
        buf_instr_r <= imem.imem_rdata;
        buf_pc_r    <= pc_f_r;
      end
      if (ifid_load_s) begin
        instr_d_r <= ifid_instr_s;
        pc_d_r    <= ifid_pc_s;
        valid_d_r <= ifid_valid_s;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed IF/ID and imem address
// expectations across fetch, stall, redirect, wrap and reset scenarios.
module tb_fetch_stage;
  logic        clk;
  logic        reset;
  logic        stall_D;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_D;
  logic [31:0] PC_D;
  logic        valid_D;
  int          errors;
  int          checks;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem),
    .stall_D     (stall_D),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_D     (instr_D),
    .PC_D        (PC_D),
    .valid_D     (valid_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, {31'd0, valid_D}, {31'd0, v});
    chk({tag, "_pc"}, PC_D, pc);
    chk({tag, "_instr"}, instr_D, ins);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    stall_D = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0000_0000;
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = 32'h0000_0000;

    // Reset state
    step();
    step();
    chk_ifid("rst", 1'b0, 32'h0000_0000, 32'h0000_0000);
    chk("rst_addr", imem.imem_addr, 32'h0000_3000);
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    reset = 1'b0;
    #1;
    chk("req_after_rst", {31'd0, imem.imem_req}, 32'd1);

    // First fetch, response one cycle after grant
    imem.imem_gnt = 1'b1;
    step();
    imem.imem_gnt = 1'b0;
    #1;
    chk("wait_req", {31'd0, imem.imem_req}, 32'd0);
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'h2408_0001;
    step();
    imem.imem_rvalid = 1'b0;
    #1;
    chk_ifid("first", 1'b1, 32'h0000_3000, 32'h2408_0001);
    chk("first_next_addr", imem.imem_addr, 32'h0000_3004);
    chk("first_next_req", {31'd0, imem.imem_req}, 32'd1);

    // Stall for 3 edges while the 0x3004 response lands in the buffer
    stall_D = 1'b1;
    imem.imem_gnt = 1'b1;
    step();
    imem.imem_gnt = 1'b0;
    chk_ifid("stall1", 1'b1, 32'h0000_3000, 32'h2408_0001);
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'h8C09_0004;
    step();
    imem.imem_rvalid = 1'b0;
    #1;
    chk_ifid("stall2", 1'b1, 32'h0000_3000, 32'h2408_0001);
    chk("stall2_req", {31'd0, imem.imem_req}, 32'd0);
    step();
    chk_ifid("stall3", 1'b1, 32'h0000_3000, 32'h2408_0001);
    chk("stall3_req", {31'd0, imem.imem_req}, 32'd0);
    stall_D = 1'b0;
    step();
    chk_ifid("unstall", 1'b1, 32'h0000_3004, 32'h8C09_0004);
    chk("unstall_addr", imem.imem_addr, 32'h0000_3008);
    chk("unstall_req", {31'd0, imem.imem_req}, 32'd1);

    // Redirect while waiting; stale response arrives two cycles later
    imem.imem_gnt = 1'b1;
    step();
    imem.imem_gnt = 1'b0;
    chk_ifid("gnt_bubble", 1'b0, 32'h0000_0000, 32'h0000_0000);
    redirect = 1'b1;
    redirect_pc = 32'h0000_3043;
    step();
    redirect = 1'b0;
    #1;
    chk("redir_addr", imem.imem_addr, 32'h0000_3040);
    chk("redir_req", {31'd0, imem.imem_req}, 32'd0);
    chk_ifid("redir", 1'b0, 32'h0000_0000, 32'h0000_0000);
    step();
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    step();
    imem.imem_rvalid = 1'b0;
    #1;
    chk_ifid("stale_drop", 1'b0, 32'h0000_0000, 32'h0000_0000);
    chk("stale_addr", imem.imem_addr, 32'h0000_3040);
    chk("stale_req", {31'd0, imem.imem_req}, 32'd1);

    // Fetch 0x3040, then redirect+stall while the next response is buffered
    imem.imem_gnt = 1'b1;
    step();
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'hAAAA_0001;
    step();
    imem.imem_rvalid = 1'b0;
    chk_ifid("f3040", 1'b1, 32'h0000_3040, 32'hAAAA_0001);
    stall_D = 1'b1;
    imem.imem_gnt = 1'b1;
    step();
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'h1111_2222;
    step();
    imem.imem_rvalid = 1'b0;
    #1;
    chk_ifid("full_hold", 1'b1, 32'h0000_3040, 32'hAAAA_0001);
    chk("full_req", {31'd0, imem.imem_req}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h0000_3100;
    step();
    redirect = 1'b0;
    stall_D = 1'b0;
    #1;
    chk_ifid("full_redir", 1'b0, 32'h0000_0000, 32'h0000_0000);
    chk("full_redir_addr", imem.imem_addr, 32'h0000_3100);
    chk("full_redir_req", {31'd0, imem.imem_req}, 32'd1);
    step();
    chk_ifid("buf_discard", 1'b0, 32'h0000_0000, 32'h0000_0000);
    imem.imem_gnt = 1'b1;
    step();
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'h3333_4444;
    step();
    imem.imem_rvalid = 1'b0;
    chk_ifid("f3100", 1'b1, 32'h0000_3100, 32'h3333_4444);

    // PC wrap at the top of the address space (low target bits masked)
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    chk("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
    imem.imem_gnt = 1'b1;
    step();
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'h5555_6666;
    step();
    chk_ifid("wrap", 1'b1, 32'hFFFF_FFFC, 32'h5555_6666);
    chk("wrap_next_addr", imem.imem_addr, 32'h0000_0000);

    // No grant, plus a spurious rvalid in REQ: PC holds, nothing delivered
    imem.imem_rdata = 32'h7777_7777;
    step();
    step();
    imem.imem_rvalid = 1'b0;
    chk_ifid("spurious", 1'b0, 32'h0000_0000, 32'h0000_0000);
    chk("nognt_addr", imem.imem_addr, 32'h0000_0000);
    chk("nognt_req", {31'd0, imem.imem_req}, 32'd1);

    // Reset while waiting; the orphaned response arrives after release
    imem.imem_gnt = 1'b1;
    step();
    imem.imem_gnt = 1'b0;
    reset = 1'b1;
    step();
    #1;
    chk("rst2_req", {31'd0, imem.imem_req}, 32'd0);
    chk("rst2_addr", imem.imem_addr, 32'h0000_3000);
    step();
    reset = 1'b0;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'h9999_9999;
    step();
    imem.imem_rvalid = 1'b0;
    imem.imem_gnt = 1'b1;
    #1;
    chk_ifid("orphan_drop", 1'b0, 32'h0000_0000, 32'h0000_0000);
    chk("orphan_req", {31'd0, imem.imem_req}, 32'd1);
    step();
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'hABCD_0001;
    step();
    imem.imem_rvalid = 1'b0;
    chk_ifid("post_rst", 1'b1, 32'h0000_3000, 32'hABCD_0001);
    chk("post_rst_addr", imem.imem_addr, 32'h0000_3004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_3000, meaning first fetch address after reset.
REQ-002 The module SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 The module SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 The module SHALL have port imem_req  output  1  fetch request valid.
REQ-005 The module SHALL have port imem_addr  output  32  fetch byte address, always equal to internal pc_F.
REQ-006 The module SHALL have port imem_gnt  input  1  memory accepts request this cycle (handshake = imem_req & imem_gnt).
REQ-007 The module SHALL have port imem_rvalid  input  1  response data valid, one cycle per accepted request, 1..N cycles after acceptance.
REQ-008 The module SHALL have port imem_rdata  input  32  instruction word, valid when imem_rvalid=1.
REQ-009 The module SHALL have port stall_D  input  1  decode cannot accept a new instruction; IF/ID register holds.
REQ-010 The module SHALL have port redirect  input  1  taken jump/branch resolved in decode; flush fetch.
REQ-011 The module SHALL have port redirect_pc  input  32  target address, valid when redirect=1.
REQ-012 The module SHALL have port instr_D  output  32  IF/ID instruction register.
REQ-013 The module SHALL have port PC_D  output  32  IF/ID PC register (PC of instr_D).
REQ-014 The module SHALL have port valid_D  output  1  instr_D/PC_D hold a real instruction; decode qualifies all control decoding with it.

Function
REQ-015 The module SHALL allow at most one outstanding imem request.
REQ-016 The FSM SHALL have states REQ (imem_req=1), WAIT (request accepted, imem_req=0), FULL (response buffered, imem_req=0).
REQ-017 REQ: imem_gnt=1 -> WAIT; otherwise stay REQ, pc_F unchanged.
REQ-018 WAIT, imem_rvalid=1, kill=0, stall_D=0: SHALL load instr_D=imem_rdata, PC_D=pc_F, valid_D=1 at the next edge, pc_F<=pc_F+4, -> REQ.
REQ-019 WAIT, imem_rvalid=1, kill=0, stall_D=1: SHALL capture imem_rdata and pc_F into an internal buffer, -> FULL; IF/ID holds.
REQ-020 FULL, stall_D=0: SHALL move buffer into IF/ID (valid_D=1), pc_F<=pc_F+4, -> REQ; FULL, stall_D=1: hold.
REQ-021 Any edge with stall_D=0 and no instruction delivered SHALL load a bubble: valid_D=0, instr_D=0, PC_D=0.
REQ-022 stall_D=1 and redirect=0 SHALL hold instr_D, PC_D, valid_D unchanged.
REQ-023 redirect=1 SHALL take priority over stall_D and all responses: next edge valid_D=0, instr_D=0, PC_D=0, pc_F<={redirect_pc[31:2],2'b00}.
REQ-024 redirect in REQ with imem_gnt=0 -> REQ; with imem_gnt=1 -> WAIT, kill<=1.
REQ-025 redirect in WAIT with imem_rvalid=0 -> WAIT, kill<=1; with imem_rvalid=1 -> REQ, response dropped.
REQ-026 redirect in FULL SHALL discard the buffer, -> REQ.
REQ-027 WAIT, imem_rvalid=1, kill=1: SHALL drop the response, clear kill, -> REQ, IF/ID gets a bubble unless stall_D=1.
REQ-028 pc_F+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-029 imem_rvalid in REQ or FULL (protocol violation) SHALL be ignored.

Reset
REQ-030 reset=1 SHALL set pc_F=RESET_PC, state=REQ, kill=0, buffer empty, instr_D=0, PC_D=0, valid_D=0 at the next edge, overriding all other inputs.
REQ-031 imem_req SHALL be 0 while reset=1; reset asserted in WAIT SHALL cause the later pending response to be ignored.

Verification
REQ-032 Reset release, imem_gnt=1, rvalid 1 cycle after grant, rdata=32'h2408_0001 -> imem_addr=32'h0000_3000; PC_D=32'h0000_3000, instr_D=32'h2408_0001, valid_D=1; next imem_addr=32'h0000_3004.
REQ-033 stall_D=1 for 3 cycles while response at 32'h0000_3004 arrives -> IF/ID unchanged, imem_req=0; stall_D drops -> PC_D=32'h0000_3004 next edge, no refetch.
REQ-034 redirect=1, redirect_pc=32'h0000_3043 while in WAIT; old response arrives 2 cycles later -> response dropped, valid_D=0, next imem_addr=32'h0000_3040.
REQ-035 redirect=1 and stall_D=1 same cycle in FULL -> valid_D=0, buffer discarded, imem_addr=redirect target.
REQ-036 pc_F=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0000_0000.
REQ-037 reset=1 asserted in WAIT, rvalid arrives after release -> ignored, first delivered instruction has PC_D=32'h0000_3000.
